// File: rtl/debounce_pkg.sv
// debounce_pkg: default timing for a 25 MHz board and width helpers shared by the debounce scanner.
package debounce_pkg;
  // 2500 cycles = 100 us per tick; 4 channels x 25 samples gives a 10 ms debounce window
  localparam int DEF_NUM_INPUTS     = 4;
  localparam int DEF_TICK_DIV       = 2500;
  localparam int DEF_STABLE_SAMPLES = 25;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int s);
    return $clog2(s + 1);
  endfunction

  localparam int DEF_IDX_W = idx_w(DEF_NUM_INPUTS);
  localparam int DEF_CNT_W = cnt_w(DEF_STABLE_SAMPLES);
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a bus of independent asynchronous inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [WIDTH-1:0] i_Async,
  output logic [WIDTH-1:0] o_Sync
);
  logic [WIDTH-1:0] r_Meta;
  logic [WIDTH-1:0] r_Sync;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Meta <= '0;
      r_Sync <= '0;
    end else begin
      r_Meta <= i_Async;
      r_Sync <= r_Meta;
    end
  end

  assign o_Sync = r_Sync;
endmodule

// File: rtl/debounce_scanner.sv
// debounce_scanner: debounces NUM_INPUTS switch lines with one round-robin scheduler
// and reports committed transitions as a press/release event stream.
module debounce_scanner
  import debounce_pkg::*;
#(
  parameter int NUM_INPUTS     = DEF_NUM_INPUTS,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic [NUM_INPUTS-1:0]        i_Bouncy,
  output logic [NUM_INPUTS-1:0]        o_Debounced,
  output logic                         o_Event_Valid,
  input  logic                         i_Event_Ready,
  output logic [idx_w(NUM_INPUTS)-1:0] o_Event_Id,
  output logic                         o_Event_Press
);
  localparam int IW = idx_w(NUM_INPUTS);
  localparam int CW = cnt_w(STABLE_SAMPLES);
  localparam int PW = $clog2(TICK_DIV);

  logic [NUM_INPUTS-1:0] w_Sync;
  logic [PW-1:0]         r_Presc;
  logic [IW-1:0]         r_Idx;
  logic [CW-1:0]         r_Cnt [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] r_Deb;
  logic                  r_Valid;
  logic [IW-1:0]         r_Id;
  logic                  r_Press;
  logic                  w_Tick;
  logic                  w_Serv;
  logic                  w_Samp;
  logic                  w_Diff;
  logic                  w_Commit;
  logic [CW-1:0]         w_Cnt;
  logic [CW-1:0]         w_Cnt_Next;

  sync_2ff #(.WIDTH(NUM_INPUTS)) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Async (i_Bouncy),
    .o_Sync  (w_Sync)
  );

  // A tick is only consumed when a commit could not overwrite an unaccepted event
  assign w_Tick     = r_Presc == PW'(TICK_DIV - 1);
  assign w_Serv     = w_Tick && (!r_Valid || i_Event_Ready);
  assign w_Samp     = w_Sync[r_Idx];
  assign w_Diff     = w_Samp != r_Deb[r_Idx];
  assign w_Cnt      = r_Cnt[r_Idx];
  assign w_Commit   = w_Serv && w_Diff && (w_Cnt == CW'(STABLE_SAMPLES - 1));
  assign w_Cnt_Next = (w_Diff && !w_Commit) ? w_Cnt + CW'(1) : '0;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Presc <= '0;
      r_Idx   <= '0;
    end else begin
      r_Presc <= w_Tick ? '0 : r_Presc + PW'(1);
      if (w_Serv)
        r_Idx <= (r_Idx == IW'(NUM_INPUTS - 1)) ? '0 : r_Idx + IW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < NUM_INPUTS; i++)
        r_Cnt[i] <= '0;
    end else if (w_Serv) begin
      r_Cnt[r_Idx] <= w_Cnt_Next;
    end
  end

  // A fresh commit wins over a same-cycle handshake so the new event is never lost
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Deb   <= '0;
      r_Valid <= 1'b0;
      r_Id    <= '0;
      r_Press <= 1'b0;
    end else if (w_Commit) begin
      r_Deb[r_Idx] <= w_Samp;
      r_Valid      <= 1'b1;
      r_Id         <= r_Idx;
      r_Press      <= w_Samp;
    end else if (i_Event_Ready) begin
      r_Valid <= 1'b0;
    end
  end

  assign o_Debounced   = r_Deb;
  assign o_Event_Valid = r_Valid;
  assign o_Event_Id    = r_Id;
  assign o_Event_Press = r_Press;
endmodule

// File: tb/tb_debounce_scanner.sv
// tb_debounce_scanner: directed stimulus with a scoreboard of expected events popped by a handshake monitor.
module tb_debounce_scanner;
  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SS = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ev_ready = 1'b1;
  logic [N-1:0] bouncy = '0;
  logic [N-1:0] deb;
  logic         ev_valid;
  logic [1:0]   ev_id;
  logic         ev_press;
  int           cyc;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    int id;
    int press;
    int at;
  } ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;

  debounce_scanner #(.NUM_INPUTS(N), .TICK_DIV(TD), .STABLE_SAMPLES(SS)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Bouncy      (bouncy),
    .o_Debounced   (deb),
    .o_Event_Valid (ev_valid),
    .i_Event_Ready (ev_ready),
    .o_Event_Id    (ev_id),
    .o_Event_Press (ev_press)
  );

  // cyc = number of rising edges since reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got id=%0d press=%0d at cyc %0d, required no event", ev_id, ev_press, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (int'(ev_id) != e.id || int'(ev_press) != e.press || (e.at >= 0 && cyc != e.at)) begin
          errors++;
          $display("FAIL event: got id=%0d press=%0d cyc=%0d, required id=%0d press=%0d cyc=%0d",
                   ev_id, ev_press, cyc, e.id, e.press, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [N-1:0] b, input logic r);
    rst_n    = 1'b0;
    bouncy   = b;
    ev_ready = r;
    @(posedge clk);
    #1;
    check("reset_debounced", int'(deb), 0);
    check("reset_valid", int'(ev_valid), 0);
    rst_n = 1'b1;
  endtask

  task automatic drained(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    // clean press on ch2, glitch on ch0, then release of ch2
    start(4'b0101, 1'b1);
    sb.push_back('{2, 1, 44});
    sb.push_back('{0, 1, 84});
    sb.push_back('{2, 0, 92});
    wait_cyc(30); bouncy[0] = 1'b0;
    wait_cyc(40); bouncy[0] = 1'b1;
    wait_cyc(46); bouncy[2] = 1'b0;
    wait_cyc(50); check("press_debounced", int'(deb), 4'b0100);
    wait_cyc(70); check("glitch_rejected", int'(deb), 4'b0100);
    wait_cyc(100); check("after_release", int'(deb), 4'b0001);
    drained("phase_a_drained");

    // async reset while ch0 event pending and ch1 count is 2
    start(4'b0011, 1'b0);
    wait_cyc(38);
    check("pending_valid", int'(ev_valid), 1);
    check("pending_id", int'(ev_id), 0);
    check("pending_debounced", int'(deb), 4'b0001);
    wait_cyc(50);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", int'(ev_valid), 0);
    check("async_debounced", int'(deb), 0);
    start(4'b0010, 1'b1);
    sb.push_back('{1, 1, 40});
    wait_cyc(30); check("fresh_count", int'(deb), 0);
    wait_cyc(60); check("fresh_commit", int'(deb), 4'b0010);
    drained("phase_b_drained");

    // backpressure: ch1 event held, scan frozen, ch3 follows after handshake
    start(4'b1010, 1'b0);
    sb.push_back('{1, 1, -1});
    sb.push_back('{3, 1, 76});
    wait_cyc(41);
    check("bp_valid", int'(ev_valid), 1);
    check("bp_id_early", int'(ev_id), 1);
    check("bp_press", int'(ev_press), 1);
    wait_cyc(69);
    check("bp_id_late", int'(ev_id), 1);
    check("bp_frozen", int'(deb), 4'b0010);
    wait_cyc(70); ev_ready = 1'b1;
    wait_cyc(90); check("bp_final", int'(deb), 4'b1010);
    drained("phase_c_drained");

    // simultaneous press on all channels
    start(4'b1111, 1'b1);
    for (int i = 0; i < N; i++) sb.push_back('{i, 1, 36 + 4 * i});
    wait_cyc(44); check("sim_partial", int'(deb), 4'b0111);
    wait_cyc(48); check("sim_all", int'(deb), 4'b1111);
    wait_cyc(60);
    drained("phase_d_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
